fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that owns the PC and drives the IF/ID pipeline register with {inst, PC+4, valid}. It issues requests on a variable-latency instruction-memory req/ack interface. It obeys the hazard-stall (hd) and flush signals that the IF/ID register receives, and accepts branch/jump redirects from ID. It sits between instruction memory and IF/ID, as the producer side of the IF/ID interface.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
NOP_INST, 32'h0000_0000, instruction word presented on bubbles/flush

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous reset, active-low
imem_req_o  out  1  fetch request; held with imem_addr_o stable until imem_ack_i
imem_addr_o  out  32  fetch address (word aligned)
imem_ack_i  in  1  data valid for current request; may be asserted in the same cycle as req (zero-wait)
imem_data_i  in  32  instruction word, valid when imem_ack_i=1
hd_i  in  1  hazard stall from hazard unit: hold IF/ID outputs and PC
flush_i  in  1  insert bubble into IF/ID; PC unaffected
redirect_i  in  1  branch/jump taken; implies flush
redirect_addr_i  in  32  new PC when redirect_i=1
inst_o  out  32  instruction to IF/ID
inst_addr_o  out  32  PC+4 of inst_o
valid_o  out  1  inst_o/inst_addr_o hold a real instruction

Behaviour:
- Reset (async, rst_n_i=0): pc=RESET_PC, state=IDLE, inst_o=NOP_INST, inst_addr_o=0, valid_o=0, skid buffer empty, imem_req_o=0. Reset mid-request abandons the outstanding request.
- imem_req_o=1 in REQ and DROP, else 0. imem_addr_o=pc in REQ; the latched old address in DROP.
- States:
  - IDLE: go to REQ next cycle unconditionally.
  - REQ:
    - ack & !hd_i & !redirect_i & !flush_i: inst_o<=imem_data_i, inst_addr_o<=pc+4, valid_o<=1, pc<=pc+4, stay in REQ. Zero-wait memory gives 1 instruction/cycle.
    - ack & hd_i & !redirect_i: outputs hold; skid<={data, pc+4}; pc<=pc+4; go to HOLD.
    - no ack & !hd_i: valid_o<=0, inst_o<=NOP_INST (bubble).
    - no ack & hd_i: outputs hold.
  - HOLD: req low. When hd_i falls, outputs<=skid, valid_o<=1, go to REQ. flush_i in HOLD empties the skid, valid_o<=0, go to REQ.
  - DROP (redirect arrived with request outstanding): req/addr held at the old values. On ack, discard the data and go to REQ at the current pc.
- Redirect (any state except IDLE): pc<=redirect_addr_i; valid_o<=0; inst_o<=NOP_INST; skid emptied.
  - Next state DROP if in REQ or DROP without ack this cycle; otherwise REQ.
  - A second redirect while in DROP updates pc and stays in DROP.
  - Redirect has priority over hd_i and flush_i.
- flush_i (no redirect): valid_o<=0, inst_o<=NOP_INST; a fetch acked that cycle is discarded and pc is not advanced (refetched). flush_i overrides hd_i for the output registers.
- PC arithmetic: 32-bit, wraps modulo 2^32 (0xFFFF_FFFC+4 -> 0). redirect_addr_i[1:0] is ignored (forced 0).
- Latency: req-to-output 1 cycle after ack. Outputs are fully registered; no combinational path from imem_data_i to inst_o.

Decomposition:
- Shared pipeline package: state encoding (IDLE/REQ/HOLD/DROP), NOP_INST constant, INST_W=32.
- One sub-module is natural: fetch_skid, a single-entry {inst, addr} buffer with load/unload/clear.

Test Plan:
- Reset release, zero-wait memory (ack=req) -> cycle 1 req=1 addr=0x0; addresses 0x0,0x4,0x8 issued back-to-back; inst_addr_o=0x4,0x8,0xC with valid_o=1 on consecutive cycles.
- 3-cycle ack latency -> imem_addr_o stable for 3 cycles; valid_o=0 bubbles between instructions; no duplicate or missing PC.
- hd_i=1 for 2 cycles coinciding with ack at addr 0x8 -> inst_o frozen, HOLD entered, req=0; after hd_i falls inst_addr_o=0xC, then fetch resumes at 0xC.
- redirect_i=1 to 0x100 while req outstanding at 0x10 (ack 2 cycles later) -> addr stays 0x10 until ack, data discarded, next req addr=0x100, first valid inst_addr_o=0x104.
- flush_i=1 with ack at 0x20 -> valid_o=0 that cycle, 0x20 refetched, then inst_addr_o=0x24.
- rst_n_i low mid-DROP -> immediately valid_o=0, req=0; after release fetch restarts at RESET_PC; PC 0xFFFF_FFFC advances to 0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM encoding, IF/ID entry and PC helpers.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_DROP
  } fetch_st_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       addr;
  } fetch_ent_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] pc_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// Single-entry {inst, addr} buffer catching a fetch that
// lands while the IF/ID register is stalled.
module fetch_skid
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       unload,
  input  logic       clear,
  input  fetch_ent_t din,
  output fetch_ent_t dout,
  output logic       full
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear || unload) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, talks req/ack to imem
// and drives the registered IF/ID bundle {inst, pc+4, valid}.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        hd_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        valid_o
);
  import fetch_pkg::*;

  fetch_st_t   state;
  logic [31:0] pc;
  logic [31:0] drop_addr;
  logic        active;
  logic        kill;
  logic        skid_load;
  logic        skid_unload;
  logic        skid_clear;
  logic        skid_full;
  fetch_ent_t  skid_din;
  fetch_ent_t  skid_dout;

  assign active      = state != ST_IDLE;
  assign imem_req_o  = (state == ST_REQ) || (state == ST_DROP);
  assign imem_addr_o = (state == ST_DROP) ? drop_addr : pc;

  assign skid_din    = '{inst: imem_data_i, addr: pc_inc(pc)};
  assign skid_load   = (state == ST_REQ) && imem_ack_i && hd_i
                    && !redirect_i && !flush_i;
  assign skid_unload = (state == ST_HOLD) && !hd_i
                    && !redirect_i && !flush_i;
  assign skid_clear  = active && (redirect_i || flush_i);

  // Bubble on redirect/flush, or a plain miss while not stalled.
  assign kill = skid_clear
             || ((state == ST_REQ) && !imem_ack_i && !hd_i);

  fetch_skid u_skid (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (skid_clear),
    .din    (skid_din),
    .dout   (skid_dout),
    .full   (skid_full)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      drop_addr   <= '0;
      inst_o      <= NOP_INST;
      inst_addr_o <= '0;
      valid_o     <= 1'b0;
    end else begin
      if (kill) begin
        valid_o <= 1'b0;
        inst_o  <= NOP_INST;
      end
      unique case (state)
        ST_IDLE: state <= ST_REQ;
        ST_REQ: begin
          if (redirect_i) begin
            pc <= pc_align(redirect_addr_i);
            if (!imem_ack_i) begin
              state     <= ST_DROP;
              drop_addr <= pc;
            end
          end else if (flush_i) begin
            state <= ST_REQ;
          end else if (imem_ack_i && !hd_i) begin
            inst_o      <= imem_data_i;
            inst_addr_o <= pc_inc(pc);
            valid_o     <= 1'b1;
            pc          <= pc_inc(pc);
          end else if (imem_ack_i) begin
            pc    <= pc_inc(pc);
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (redirect_i) begin
            pc    <= pc_align(redirect_addr_i);
            state <= ST_REQ;
          end else if (flush_i) begin
            state <= ST_REQ;
          end else if (!hd_i) begin
            inst_o      <= skid_dout.inst;
            inst_addr_o <= skid_dout.addr;
            valid_o     <= skid_full;
            state       <= ST_REQ;
          end
        end
        ST_DROP: begin
          // The stale response is swallowed; pc already holds the target.
          if (redirect_i) pc <= pc_align(redirect_addr_i);
          if (imem_ack_i) state <= ST_REQ;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level
// model of the expected instruction stream.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req;
  logic [31:0] addr;
  logic        ack = 1'b0;
  logic [31:0] data = '0;
  logic        hd = 1'b0;
  logic        fl = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] rda = '0;
  logic [31:0] inst;
  logic [31:0] iaddr;
  logic        valid;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .NOP_INST (NOP)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .imem_req_o      (req),
    .imem_addr_o     (addr),
    .imem_ack_i      (ack),
    .imem_data_i     (data),
    .hd_i            (hd),
    .flush_i         (fl),
    .redirect_i      (rd),
    .redirect_addr_i (rda),
    .inst_o          (inst),
    .inst_addr_o     (iaddr),
    .valid_o         (valid)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  // model: next PC owed to IF/ID, fetched-but-stalled word,
  // and a request made obsolete by a redirect
  logic [31:0] exp_pc;
  logic        pending;
  logic        stale;
  logic [31:0] stale_addr;
  logic [31:0] o_inst, o_iaddr;
  logic        o_valid;
  logic        first_cyc;
  logic        p_req, p_ack, p_hd, p_fl, p_rd;
  logic [31:0] p_addr, p_rda;
  int          lat_fix = 0;
  int          lat = 0;
  int          cnt = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a ^ 32'hDEAD_0000) | 32'h3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    exp_pc    = RST_PC;
    pending   = 1'b0;
    stale     = 1'b0;
    o_inst    = NOP;
    o_iaddr   = '0;
    o_valid   = 1'b0;
    p_req     = 1'b0;
    p_ack     = 1'b0;
    first_cyc = 1'b1;
  endtask

  // called at a negedge; returns at the next negedge
  task automatic do_reset();
    #2 rst_n = 1'b0;
    ack = 1'b0; hd = 1'b0; fl = 1'b0; rd = 1'b0;
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_iaddr", iaddr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cycle(input logic h, input logic f, input logic r,
                       input logic [31:0] ra);
    logic a;
    if (first_cyc) begin
      h = 1'b0; f = 1'b0; r = 1'b0;
      chk("req_idle", 32'(req), 32'd0);
    end else begin
      chk("req", 32'(req), 32'(!pending));
    end
    a = 1'b0;
    if (req) begin
      chk("addr", addr, stale ? stale_addr : exp_pc);
      if (!p_req || p_ack) begin
        lat = (lat_fix < 0) ? int'($urandom_range(0, 3)) : lat_fix;
        cnt = 0;
      end
      a = (cnt == lat);
      cnt++;
    end
    ack  = a;
    data = a ? memf(addr) : $urandom;
    hd = h; fl = f; rd = r; rda = ra;
    p_req = req; p_addr = addr; p_ack = a;
    p_hd = h; p_fl = f; p_rd = r; p_rda = ra;

    @(negedge clk);
    first_cyc = 1'b0;
    if (p_rd || p_fl) begin
      chk("kill_valid", 32'(valid), 32'd0);
      chk("kill_inst", inst, NOP);
      if (p_rd) begin
        exp_pc  = p_rda & ~32'h3;
        pending = 1'b0;
        if (p_req && !p_ack) begin
          stale      = 1'b1;
          stale_addr = p_addr;
        end else begin
          stale = 1'b0;
        end
      end else begin
        if (pending) begin
          exp_pc  = exp_pc + 32'd4;
          pending = 1'b0;
        end
        if (p_ack) stale = 1'b0;
      end
    end else if (p_hd) begin
      chk("hold_valid", 32'(valid), 32'(o_valid));
      chk("hold_inst", inst, o_inst);
      chk("hold_iaddr", iaddr, o_iaddr);
      if (p_ack) begin
        if (stale) stale = 1'b0;
        else pending = 1'b1;
      end
    end else if (pending || (p_ack && !stale)) begin
      chk("dlv_valid", 32'(valid), 32'd1);
      chk("dlv_iaddr", iaddr, exp_pc + 32'd4);
      chk("dlv_inst", inst, memf(exp_pc));
      exp_pc  = exp_pc + 32'd4;
      pending = 1'b0;
    end else begin
      chk("bub_valid", 32'(valid), 32'd0);
      chk("bub_inst", inst, NOP);
      if (p_ack) stale = 1'b0;
    end
    o_inst  = inst;
    o_iaddr = iaddr;
    o_valid = valid;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    logic seen;
    logic [31:0] ra;
    model_reset();
    @(negedge clk);
    do_reset();

    // zero-wait streaming
    lat_fix = 0;
    idle(6);

    // three-cycle memory
    lat_fix = 2;
    idle(12);

    // stall landing on the ack at 0x8
    do_reset();
    lat_fix = 0;
    idle(3);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    idle(4);

    // redirect to 0x100 while 0x10 is outstanding
    do_reset();
    lat_fix = 0;
    idle(5);
    lat_fix = 2;
    cycle(1'b0, 1'b0, 1'b1, 32'h100);
    idle(2);
    lat_fix = 0;
    idle(4);

    // flush on the ack at 0x20
    do_reset();
    lat_fix = 0;
    idle(9);
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    idle(3);

    // random traffic
    lat_fix = -1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        ra = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else
        ra = $urandom & 32'h0000_FFFF;
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 19) == 0, ra);
    end

    // reset while a request is being dropped
    do_reset();
    lat_fix = 3;
    idle(1);
    cycle(1'b0, 1'b0, 1'b1, 32'h40);
    idle(1);
    do_reset();

    // PC wrap
    lat_fix = 0;
    idle(1);
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (valid && iaddr == 32'h0) seen = 1'b1;
    end
    chk("wrap", 32'(seen), 32'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
